// File: rtl/dpram_pkg.sv
// Shared definitions for the parametrised simple dual-port RAM.
// Holds read-during-write mode constants, clear FSM state encoding and
// the byte-merge helper used by both the write path and write-through.
package dpram_pkg;

  // Same-address read-during-write behaviour
  localparam int RDW_OLD = 0;  // read returns the pre-write word
  localparam int RDW_NEW = 1;  // read returns the pre-write word merged with enabled bytes

  // Widest word the merge helper handles; callers zero-extend into it
  // and truncate the result back to their own width.
  localparam int MAX_DW = 1024;
  localparam int MAX_BW = MAX_DW / 8;

  typedef logic [MAX_DW-1:0] word_max_t;
  typedef logic [MAX_BW-1:0] be_max_t;

  // Clear sweep runs first after reset, then the RAM serves ports
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Replace each byte of old_w whose enable is set with the byte of new_w
  function automatic word_max_t byte_merge(input word_max_t old_w,
                                           input word_max_t new_w,
                                           input be_max_t   be);
    word_max_t res;
    res = old_w;
    for (int i = 0; i < MAX_BW; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dpram_clear_fsm.sv
// Post-reset clear sequencer: walks every address once writing zeros.
// Latency: sweep lasts 2**ADDR_WIDTH cycles after the last reset cycle.
// No backpressure: busy_o tells the top level to ignore both ports.
module dpram_clear_fsm
  import dpram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  busy_o,
  output logic                  clr_wen_o,
  output logic [ADDR_WIDTH-1:0] clr_addr_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;

  // State and sweep counter; reset restarts the sweep from address 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Advance the sweep one word per cycle, leave CLEAR after the last word
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        if (clr_addr_q == LAST_ADDR) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // Busy for the whole sweep; the zero write is held off while reset is active
  always_comb begin
    busy_o     = (state_q == ST_CLEAR);
    clr_wen_o  = (state_q == ST_CLEAR) && !rst;
    clr_addr_o = clr_addr_q;
  end

endmodule

// File: rtl/dpram_param.sv
// Parametrised simple dual-port RAM with byte enables and selectable RDW mode.
// Latency: read data 1 cycle after acceptance, 2 with OUT_REG=1.
// No backpressure; both ports ignored while busy (post-reset clear sweep).
module dpram_param
  import dpram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int OUT_REG    = 0,
  parameter int RDW_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wen,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]   d_in,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic                    ren,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]   d_out,
  output logic                    d_valid,
  output logic                    busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int BE_W  = DATA_WIDTH / 8;

  // Width-adapted wrapper around the package merge helper
  function automatic logic [DATA_WIDTH-1:0] merge_w(input logic [DATA_WIDTH-1:0] old_w,
                                                    input logic [DATA_WIDTH-1:0] new_w,
                                                    input logic [BE_W-1:0]       b);
    return DATA_WIDTH'(byte_merge(word_max_t'(old_w), word_max_t'(new_w), be_max_t'(b)));
  endfunction

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    clr_wen;
  logic [ADDR_WIDTH-1:0]   clr_addr;

  logic                    wr_acc;
  logic                    rd_acc;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_dat;
  logic [DATA_WIDTH-1:0]   rd_old;
  logic                    rdw_hit;
  logic [DATA_WIDTH-1:0]   rd_word;

  logic [DATA_WIDTH-1:0]   rd_dat_q;
  logic                    rd_vld_q;

  dpram_clear_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_fsm (
    .clk        (clk),
    .rst        (rst),
    .busy_o     (busy),
    .clr_wen_o  (clr_wen),
    .clr_addr_o (clr_addr)
  );

  // Port acceptance: reset and the clear sweep both block user traffic
  always_comb begin
    wr_acc = wen && !busy && !rst;
    rd_acc = ren && !busy && !rst;
  end

  // Write-port mux: clear sweep zeroes whole words, otherwise a byte-merged user write
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = waddr;
    wr_dat  = '0;
    if (clr_wen) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_dat  = '0;
    end else begin
      wr_en   = wr_acc;
      wr_addr = waddr;
      wr_dat  = merge_w(mem_q[waddr], d_in, be);
    end
  end

  // Memory array; contents are defined by the clear sweep, not by reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_dat;
    end
  end

  // Read word selection, with write-through merge on a same-address collision
  always_comb begin
    rd_old  = mem_q[raddr];
    rdw_hit = wr_acc && rd_acc && (raddr == waddr);
    rd_word = rd_old;
    if ((RDW_MODE == RDW_NEW) && rdw_hit) begin
      rd_word = merge_w(rd_old, d_in, be);
    end
  end

  // First read stage: data captured only on accepted reads, valid follows the strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_dat_q <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      rd_vld_q <= rd_acc;
      if (rd_acc) begin
        rd_dat_q <= rd_word;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] out_dat_q;
    logic                  out_vld_q;

    // Optional output stage: one more cycle of delay, same hold semantics
    always_ff @(posedge clk) begin
      if (rst) begin
        out_dat_q <= '0;
        out_vld_q <= 1'b0;
      end else begin
        out_vld_q <= rd_vld_q;
        if (rd_vld_q) begin
          out_dat_q <= rd_dat_q;
        end
      end
    end

    assign d_out   = out_dat_q;
    assign d_valid = out_vld_q;
  end else begin : g_no_out_reg
    assign d_out   = rd_dat_q;
    assign d_valid = rd_vld_q;
  end

endmodule

// File: tb/tb_dpram_param.sv
// Directed bench for dpram_param: two instances share stimulus,
// d0 = OUT_REG 0 / RDW old-data, d1 = OUT_REG 1 / RDW write-through.
module tb_dpram_param;

  logic        clk;
  logic        rst;
  logic        wen;
  logic [3:0]  waddr;
  logic [31:0] d_in;
  logic [3:0]  be;
  logic        ren;
  logic [3:0]  raddr;

  logic [31:0] d0_out, d1_out;
  logic        d0_vld, d1_vld;
  logic        d0_busy, d1_busy;

  int n_checks;
  int n_errors;

  logic [31:0] exp0 [16];
  logic [31:0] exp1 [16];

  dpram_param #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (4),
    .OUT_REG    (0),
    .RDW_MODE   (0)
  ) u_d0 (
    .clk     (clk),
    .rst     (rst),
    .wen     (wen),
    .waddr   (waddr),
    .d_in    (d_in),
    .be      (be),
    .ren     (ren),
    .raddr   (raddr),
    .d_out   (d0_out),
    .d_valid (d0_vld),
    .busy    (d0_busy)
  );

  dpram_param #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (4),
    .OUT_REG    (1),
    .RDW_MODE   (1)
  ) u_d1 (
    .clk     (clk),
    .rst     (rst),
    .wen     (wen),
    .waddr   (waddr),
    .d_in    (d_in),
    .be      (be),
    .ren     (ren),
    .raddr   (raddr),
    .d_out   (d1_out),
    .d_valid (d1_vld),
    .busy    (d1_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle so outputs can be sampled
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    wen   = 1'b1;
    waddr = a;
    d_in  = d;
    be    = b;
    tick();
    wen   = 1'b0;
  endtask

  // Back-to-back reads from base; d0 checked one cycle after issue, d1 two
  task automatic rd_burst(input int base, input int n);
    for (int i = 0; i <= n; i++) begin
      ren   = (i < n);
      raddr = 4'(base + i);
      tick();
      if (i < n) begin
        chk($sformatf("rd0[%0d]", base + i), d0_out, exp0[i]);
        chk($sformatf("vld0[%0d]", base + i), {31'd0, d0_vld}, 32'd1);
      end
      if (i >= 1) begin
        chk($sformatf("rd1[%0d]", base + i - 1), d1_out, exp1[i-1]);
        chk($sformatf("vld1[%0d]", base + i - 1), {31'd0, d1_vld}, 32'd1);
      end
    end
    ren = 1'b0;
  endtask

  // Count busy cycles from the current sample until the sweep ends (bounded)
  task automatic count_busy(output int n0, output int n1, output logic vseen);
    n0    = 0;
    n1    = 0;
    vseen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!d0_busy && !d1_busy) break;
      n0    += int'(d0_busy);
      n1    += int'(d1_busy);
      vseen |= d0_vld | d1_vld;
      tick();
    end
  endtask

  initial begin
    int   nb0, nb1;
    logic vs;

    n_checks = 0;
    n_errors = 0;
    rst   = 1'b1;
    wen   = 1'b0;
    waddr = '0;
    d_in  = '0;
    be    = '0;
    ren   = 1'b0;
    raddr = '0;

    // Reset for two cycles
    tick();
    tick();
    chk("rst_dout0", d0_out, 32'h0);
    chk("rst_dout1", d1_out, 32'h0);
    chk("rst_vld0", {31'd0, d0_vld}, 32'd0);
    chk("rst_vld1", {31'd0, d1_vld}, 32'd0);
    chk("rst_busy0", {31'd0, d0_busy}, 32'd1);
    chk("rst_busy1", {31'd0, d1_busy}, 32'd1);

    // Sweep with ren pulsed throughout; no read may be accepted
    rst = 1'b0;
    ren = 1'b1;
    count_busy(nb0, nb1, vs);
    ren = 1'b0;
    chk("sweep_busy0", 32'(nb0), 32'd16);
    chk("sweep_busy1", 32'(nb1), 32'd16);
    chk("sweep_vld", {31'd0, vs}, 32'd0);
    chk("sweep_end_vld0", {31'd0, d0_vld}, 32'd0);

    // Cleared contents
    for (int a = 0; a < 16; a++) begin
      exp0[a] = 32'h0;
      exp1[a] = 32'h0;
    end
    rd_burst(0, 16);

    // Full sweep write then back-to-back read
    for (int a = 0; a < 16; a++) begin
      wr(4'(a), 32'(a) * 32'h01010101, 4'hF);
      exp0[a] = 32'(a) * 32'h01010101;
      exp1[a] = 32'(a) * 32'h01010101;
    end
    rd_burst(0, 16);

    // Byte enables
    wr(4'd5, 32'hAABBCCDD, 4'hF);
    wr(4'd5, 32'h11223344, 4'b0101);
    exp0[0] = 32'hAA22CC44;
    exp1[0] = 32'hAA22CC44;
    rd_burst(5, 1);

    // Read during write at address 7 holding zero
    wr(4'd7, 32'h0, 4'hF);
    wen = 1'b1; waddr = 4'd7; d_in = 32'hDEADBEEF; be = 4'b0011;
    ren = 1'b1; raddr = 4'd7;
    tick();
    wen = 1'b0;
    chk("rdw_old0", d0_out, 32'h00000000);
    tick();
    chk("rdw_new1", d1_out, 32'h0000BEEF);
    chk("rdw_next0", d0_out, 32'h0000BEEF);
    ren = 1'b0;
    tick();
    chk("rdw_next1", d1_out, 32'h0000BEEF);
    chk("rdw_idle_vld0", {31'd0, d0_vld}, 32'd0);

    // Simultaneous read and write at different addresses
    wen = 1'b1; waddr = 4'd8; d_in = 32'hCAFEF00D; be = 4'hF;
    ren = 1'b1; raddr = 4'd9;
    tick();
    wen = 1'b0;
    ren = 1'b0;
    chk("diff_addr0", d0_out, 32'h09090909);
    tick();
    chk("diff_addr1", d1_out, 32'h09090909);
    exp0[0] = 32'hCAFEF00D;
    exp1[0] = 32'hCAFEF00D;
    rd_burst(8, 1);

    // Hold: output keeps last read while writes go elsewhere
    wr(4'd3, 32'h12345678, 4'hF);
    ren = 1'b1; raddr = 4'd3;
    tick();
    ren = 1'b0;
    chk("hold_rd0", d0_out, 32'h12345678);
    for (int h = 0; h < 3; h++) begin
      wen = 1'b1; waddr = 4'(10 + h); d_in = 32'hA0A00000 + 32'(h); be = 4'hF;
      tick();
      chk($sformatf("hold_d0[%0d]", h), d0_out, 32'h12345678);
      chk($sformatf("hold_v0[%0d]", h), {31'd0, d0_vld}, 32'd0);
      chk($sformatf("hold_d1[%0d]", h), d1_out, 32'h12345678);
      chk($sformatf("hold_v1[%0d]", h), {31'd0, d1_vld}, (h == 0) ? 32'd1 : 32'd0);
      exp0[h] = 32'hA0A00000 + 32'(h);
      exp1[h] = 32'hA0A00000 + 32'(h);
    end
    wen = 1'b0;
    rd_burst(10, 3);

    // Mid-sweep reset restarts the sweep
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 9; c++) tick();
    chk("mid_busy", {31'd0, d0_busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_busy(nb0, nb1, vs);
    chk("mid_busy0", 32'(nb0), 32'd16);
    chk("mid_busy1", 32'(nb1), 32'd16);
    chk("mid_vld", {31'd0, vs}, 32'd0);
    for (int a = 0; a < 16; a++) begin
      exp0[a] = 32'h0;
      exp1[a] = 32'h0;
    end
    rd_burst(0, 16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dpram_param.md
# dpram_param

Parametrised simple dual-port RAM (one write port, one read port, one clock) for the cell library. It generalises the fixed 32x1024 dpram with configurable width and depth, per-byte write enables, and a selectable read-during-write mode. It adds an optional output register and a hardware clear sweep after reset. It is the behavioural model used by memory-block architectures and their Verilog testbenches.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 10, address width; DEPTH = 2**ADDR_WIDTH words.
- OUT_REG, 0, 1 adds an output pipeline register, making read latency 2.
- RDW_MODE, 0, same-address read during write: 0 = old data, 1 = new data (write-through, merged per byte).
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- wen  in  1  write enable.
- waddr  in  ADDR_WIDTH  write address.
- d_in  in  DATA_WIDTH  write data.
- be  in  DATA_WIDTH/8  byte enables; be[i] gates d_in[8i+7:8i].
- ren  in  1  read enable.
- raddr  in  ADDR_WIDTH  read address.
- d_out  out  DATA_WIDTH  read data.
- d_valid  out  1  d_out carries data from an accepted read.
- busy  out  1  clear sweep in progress; ports ignored.

## Operation
- FSM states are CLEAR and READY.
- rst=1 forces CLEAR and clr_addr=0, clears the pipeline, and sets d_out=0 and d_valid=0. Reset has priority over every other input.
- In CLEAR, mem[clr_addr] is written with all zeros each cycle and clr_addr increments. When clr_addr=DEPTH-1 has been written, the FSM moves to READY on the next edge.
- busy=1 exactly in CLEAR. wen and ren are ignored in CLEAR; no read is accepted and d_valid stays 0.
- Asserting rst mid-sweep restarts the sweep from address 0.
- In READY, a write occurs when wen=1. Each byte i with be[i]=1 updates; other bytes retain their value. wen=1 with be=0 is a no-op.
- In READY, a read is accepted when ren=1. With ren=0, d_out holds its last value and d_valid drops to 0 for the corresponding output cycle.
- Read during write, when both are accepted and raddr==waddr:
  - RDW_MODE=0 returns the pre-write word.
  - RDW_MODE=1 returns the pre-write word with the enabled bytes replaced by d_in.
- A read during write at different addresses has no interaction.
- Addresses wrap naturally: every ADDR_WIDTH value is a valid location, so no out-of-range case exists.

## Timing
- Read latency with OUT_REG=0: read accepted at edge N; d_out/d_valid are valid after edge N, i.e. during cycle N+1.
- Read latency with OUT_REG=1: valid after edge N+1.
- d_valid is a pure delay of the accepted-read strobe, by 1 or 2 cycles.
- Write data is visible to a read accepted on the cycle after the write in either mode. It is visible on the same cycle only with RDW_MODE=1.
- The clear sweep takes DEPTH cycles after the last cycle with rst=1: busy=1 for DEPTH cycles, then 0.
- Reset values: d_out=0, d_valid=0, busy=1. The OUT_REG stage also resets to 0.
- Back-to-back reads and writes are supported every cycle, with no bubbles in READY.

## Structure
- Shared package dpram_pkg:
  - RDW_OLD=0 and RDW_NEW=1 constants.
  - State encoding for CLEAR/READY.
  - A byte-merge function (old word, new word, be) -> merged word, used by both the write path and write-through.
- Sub-module dpram_clear_fsm:
  - Contains the state register, clr_addr counter and busy output.
  - Drives the clear write (address, enable, zero data) that muxes into the write port.
- Top level holds the memory array, write mux, read/RDW logic and optional output stage.

## Test plan
- Reset and clear with ADDR_WIDTH=4:
  - Stimulus: rst for 2 cycles, then 0; pulse ren during the sweep.
  - Response: busy=1 for exactly 16 cycles and d_valid stays 0; afterwards, reading all 16 addresses returns 0x00000000.
- Full sweep:
  - Stimulus: write mem[a] = a*0x01010101 for a=0..1023 with be=4'hF, then read 0..1023 back to back.
  - Response: each d_out matches, d_valid is continuous, and latency is 1 (OUT_REG=0) or 2 (OUT_REG=1).
- Byte enables:
  - Stimulus: write 0xAABBCCDD to address 5, then write 0x11223344 with be=4'b0101, then read address 5.
  - Response: 0xAA22CC44.
- Read during write at address 7 holding 0x0:
  - Stimulus: same cycle wen/ren, d_in=0xDEADBEEF, be=4'b0011.
  - Response: RDW_MODE=0 gives 0x00000000; RDW_MODE=1 gives 0x0000BEEF. A read in the next cycle gives 0x0000BEEF in both modes.
- Mid-sweep reset with ADDR_WIDTH=4:
  - Stimulus: assert rst at sweep cycle 9.
  - Response: the sweep restarts and busy=1 for 16 cycles after rst deasserts.
- Hold behaviour:
  - Stimulus: read 0x12345678, then ren=0 for 3 cycles while writes proceed to other addresses.
  - Response: d_out holds 0x12345678 and d_valid=0 during the hold.
